// File: rtl/program_counter_gen2.sv
// rtl/program_counter_gen2.sv - program counter with branch/jump/call/return, return-address stack and halt FSM
// PC values are kept mod MAX_INST_COUNT; the RAS drops its oldest entry when pushed while full.
module program_counter_gen2 #(
  parameter int PC_WIDTH       = 5,
  parameter int MAX_INST_COUNT = 17,
  parameter int RAS_DEPTH      = 4
) (
  input  logic                             Clock,
  input  logic                             peripheral_reset,
  input  logic                             en_pc,
  input  logic                             branch_op,
  input  logic                             branch_mode,
  input  logic [31:0]                      alu_result_in,
  input  logic [PC_WIDTH-1:0]              Immediate_branch_in,
  input  logic                             jump_op,
  input  logic                             call_op,
  input  logic                             ret_op,
  input  logic [PC_WIDTH-1:0]              jump_target_in,
  input  logic                             halt_req,
  input  logic                             resume,
  output logic [PC_WIDTH-1:0]              pc_out,
  output logic                             redirect,
  output logic                             halted,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic                             ras_overflow,
  output logic                             ras_underflow
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic signed [PC_WIDTH+1:0] MAX_S = (PC_WIDTH+2)'(MAX_INST_COUNT);
  localparam logic signed [PC_WIDTH+1:0] ONE_S = (PC_WIDTH+2)'(1);
  localparam logic [CNT_W-1:0]           FULL  = CNT_W'(RAS_DEPTH);
  localparam logic [CNT_W-1:0]           CNT1  = CNT_W'(1);

  typedef enum logic {
    S_RUN,
    S_HALTED
  } state_t;

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic                  redirect_q, redirect_d;
  logic [PC_WIDTH-1:0]   ras_q [RAS_DEPTH];
  logic [PC_WIDTH-1:0]   ras_d [RAS_DEPTH];
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic [PC_WIDTH-1:0]   seq_pc;
  logic [PC_WIDTH-1:0]   branch_pc;
  logic [PC_WIDTH-1:0]   jump_pc;
  logic                  branch_taken;

  // Two guard bits cover both the negative and the >= MAX range; one correction suffices.
  function automatic logic [PC_WIDTH-1:0] wrap_pc(input logic signed [PC_WIDTH+1:0] v);
    logic signed [PC_WIDTH+1:0] r;
    r = v;
    if (v < 0) begin
      r = v + MAX_S;
    end else if (v >= MAX_S) begin
      r = v - MAX_S;
    end
    return r[PC_WIDTH-1:0];
  endfunction

  always_comb begin
    seq_pc       = wrap_pc($signed({2'b00, pc_q}) + ONE_S);
    branch_pc    = wrap_pc($signed({2'b00, pc_q}) +
                           $signed({{2{Immediate_branch_in[PC_WIDTH-1]}}, Immediate_branch_in}));
    jump_pc      = wrap_pc($signed({2'b00, jump_target_in}));
    branch_taken = branch_op && (branch_mode ? (alu_result_in != '0) : (alu_result_in == '0));
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_d = 1'b0;
    ras_d      = ras_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;

    case (state_q)
      S_RUN: begin
        if (halt_req) begin
          state_d = S_HALTED;
        end else if (en_pc) begin
          if (ret_op) begin
            if (cnt_q != '0) begin
              pc_d       = ras_q[0];
              redirect_d = 1'b1;
              cnt_d      = cnt_q - CNT1;
              for (int i = 0; i < RAS_DEPTH - 1; i++) begin
                ras_d[i] = ras_q[i+1];
              end
              ras_d[RAS_DEPTH-1] = '0;
            end else begin
              pc_d  = seq_pc;
              unf_d = 1'b1;
            end
          end else if (call_op) begin
            pc_d       = jump_pc;
            redirect_d = 1'b1;
            // Shifting toward the bottom drops the oldest entry when the stack is full.
            for (int i = RAS_DEPTH - 1; i > 0; i--) begin
              ras_d[i] = ras_q[i-1];
            end
            ras_d[0] = seq_pc;
            if (cnt_q == FULL) begin
              ovf_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT1;
            end
          end else if (jump_op) begin
            pc_d       = jump_pc;
            redirect_d = 1'b1;
          end else if (branch_taken) begin
            pc_d       = branch_pc;
            redirect_d = 1'b1;
          end else begin
            pc_d = seq_pc;
          end
        end
      end
      S_HALTED: begin
        if (resume && !halt_req) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (peripheral_reset) begin
      state_q    <= S_RUN;
      pc_q       <= '0;
      redirect_q <= 1'b0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      ras_q      <= ras_d;
    end
  end

  assign pc_out        = pc_q;
  assign redirect      = redirect_q;
  assign halted        = (state_q == S_HALTED);
  assign ras_count     = cnt_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule

// File: tb/tb_program_counter_gen2.sv
// tb/tb_program_counter_gen2.sv - directed self-checking bench for program_counter_gen2
module tb_program_counter_gen2;

  logic        Clock;
  logic        peripheral_reset;
  logic        en_pc;
  logic        branch_op;
  logic        branch_mode;
  logic [31:0] alu_result_in;
  logic [4:0]  Immediate_branch_in;
  logic        jump_op;
  logic        call_op;
  logic        ret_op;
  logic [4:0]  jump_target_in;
  logic        halt_req;
  logic        resume;
  logic [4:0]  pc_out;
  logic        redirect;
  logic        halted;
  logic [2:0]  ras_count;
  logic        ras_overflow;
  logic        ras_underflow;

  int checks;
  int failures;

  program_counter_gen2 #(
    .PC_WIDTH(5),
    .MAX_INST_COUNT(17),
    .RAS_DEPTH(4)
  ) dut (
    .Clock(Clock),
    .peripheral_reset(peripheral_reset),
    .en_pc(en_pc),
    .branch_op(branch_op),
    .branch_mode(branch_mode),
    .alu_result_in(alu_result_in),
    .Immediate_branch_in(Immediate_branch_in),
    .jump_op(jump_op),
    .call_op(call_op),
    .ret_op(ret_op),
    .jump_target_in(jump_target_in),
    .halt_req(halt_req),
    .resume(resume),
    .pc_out(pc_out),
    .redirect(redirect),
    .halted(halted),
    .ras_count(ras_count),
    .ras_overflow(ras_overflow),
    .ras_underflow(ras_underflow)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    en_pc = 0; branch_op = 0; branch_mode = 0; alu_result_in = 0;
    Immediate_branch_in = 0; jump_op = 0; call_op = 0; ret_op = 0;
    jump_target_in = 0; halt_req = 0; resume = 0;
  endtask

  task automatic do_reset();
    idle();
    peripheral_reset = 1;
    step();
    peripheral_reset = 0;
  endtask

  task automatic jump_to(input logic [4:0] t);
    idle();
    en_pc = 1; jump_op = 1; jump_target_in = t;
    step();
    idle();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"}, 32'(pc_out), 0);
    check({tag, "_redirect"}, 32'(redirect), 0);
    check({tag, "_halted"}, 32'(halted), 0);
    check({tag, "_ras_count"}, 32'(ras_count), 0);
    check({tag, "_ovf"}, 32'(ras_overflow), 0);
    check({tag, "_unf"}, 32'(ras_underflow), 0);
  endtask

  initial begin
    int exp_pops[4];
    checks = 0;
    failures = 0;
    peripheral_reset = 0;
    idle();

    do_reset();
    check_reset_state("reset");

    // Sequential run with wrap at 17
    en_pc = 1;
    for (int i = 1; i <= 18; i++) begin
      step();
      check("seq_pc", 32'(pc_out), 32'(i % 17));
      check("seq_redirect", 32'(redirect), 0);
    end
    idle();
    step();
    check("hold_en0_pc", 32'(pc_out), 1);

    // Backward branch taken, then untaken with mode 1
    jump_to(3);
    en_pc = 1; branch_op = 1; branch_mode = 0; alu_result_in = 0; Immediate_branch_in = 5'b11110;
    step();
    check("br_back_pc", 32'(pc_out), 1);
    check("br_back_redirect", 32'(redirect), 1);
    jump_to(3);
    en_pc = 1; branch_op = 1; branch_mode = 1; alu_result_in = 0; Immediate_branch_in = 5'b11110;
    step();
    check("br_nt_pc", 32'(pc_out), 4);
    check("br_nt_redirect", 32'(redirect), 0);
    alu_result_in = 5;
    step();
    check("br_m1_pc", 32'(pc_out), 2);
    check("br_m1_redirect", 32'(redirect), 1);

    // Branch wraps past 16; jump target 20 wraps to 3; jump beats branch
    jump_to(15);
    en_pc = 1; branch_op = 1; branch_mode = 0; alu_result_in = 0; Immediate_branch_in = 5'd4;
    step();
    check("br_wrap_pc", 32'(pc_out), 2);
    idle();
    en_pc = 1; jump_op = 1; jump_target_in = 5'd20;
    step();
    check("jmp_wrap_pc", 32'(pc_out), 3);
    check("jmp_wrap_redirect", 32'(redirect), 1);
    idle();
    en_pc = 1; jump_op = 1; jump_target_in = 5'd7;
    branch_op = 1; Immediate_branch_in = 5'd1;
    step();
    check("jmp_prio_pc", 32'(pc_out), 7);
    idle();
    step();
    check("redirect_clears", 32'(redirect), 0);

    // Five calls overflow the 4-deep stack
    do_reset();
    for (int p = 0; p < 5; p++) begin
      jump_to(5'(p));
      en_pc = 1; call_op = 1; jump_target_in = 5'd10;
      step();
      check("call_pc", 32'(pc_out), 10);
      check("call_redirect", 32'(redirect), 1);
    end
    check("call_ras_count", 32'(ras_count), 4);
    check("call_ovf", 32'(ras_overflow), 1);
    check("call_unf", 32'(ras_underflow), 0);

    exp_pops = '{5, 4, 3, 2};
    idle();
    en_pc = 1; ret_op = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("ret_pc", 32'(pc_out), 32'(exp_pops[k]));
      check("ret_redirect", 32'(redirect), 1);
    end
    check("ret_ras_count", 32'(ras_count), 0);
    step();
    check("ret_empty_pc", 32'(pc_out), 3);
    check("ret_empty_redirect", 32'(redirect), 0);
    check("ret_empty_unf", 32'(ras_underflow), 1);
    check("ovf_sticky", 32'(ras_overflow), 1);
    call_op = 1; jump_target_in = 5'd12;
    step();
    check("callret_pc", 32'(pc_out), 4);
    check("callret_ras_count", 32'(ras_count), 0);

    // Halt / resume
    jump_to(6);
    en_pc = 1; halt_req = 1;
    step();
    check("halt_pc", 32'(pc_out), 6);
    check("halt_halted", 32'(halted), 1);
    halt_req = 0; call_op = 1; jump_target_in = 5'd9;
    step();
    check("halted_hold_pc", 32'(pc_out), 6);
    check("halted_hold_ras", 32'(ras_count), 0);
    call_op = 0; resume = 1; halt_req = 1;
    step();
    check("resume_blocked", 32'(halted), 1);
    halt_req = 0;
    step();
    check("resume_halted", 32'(halted), 0);
    check("resume_pc", 32'(pc_out), 6);
    resume = 0;
    step();
    check("after_resume_pc", 32'(pc_out), 7);

    // Fill stack, halt, then reset while halted
    idle();
    en_pc = 1; call_op = 1; jump_target_in = 5'd10;
    for (int k = 0; k < 4; k++) step();
    check("fill_ras_count", 32'(ras_count), 4);
    idle();
    halt_req = 1;
    step();
    check("fill_halted", 32'(halted), 1);
    check("fill_unf", 32'(ras_underflow), 1);
    halt_req = 1; en_pc = 1; call_op = 1; peripheral_reset = 1;
    step();
    peripheral_reset = 0;
    idle();
    check_reset_state("halt_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
